// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(15,11) codeword layout.
`default_nettype none

package hamming_pkg;

  localparam int CODE_W = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  localparam int PAR_IDX_0 = 0;
  localparam int PAR_IDX_1 = 1;
  localparam int PAR_IDX_2 = 3;
  localparam int PAR_IDX_3 = 7;

  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  function automatic logic [DATA_W-1:0] extrai_dados(input logic [CODE_W-1:0] codeword);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int j = 0; j < DATA_W; j++) begin
      d[j] = codeword[DATA_IDX[j]];
    end
    return d;
  endfunction

  // Indices whose Hamming position (index+1) has bit k set.
  function automatic logic [CODE_W-1:0] mascara_paridade(input int k);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_W; i++) begin
      m[i] = (((i + 1) >> k) % 2) == 1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sindrome_hamming.sv
// Combinational Hamming(15,11) syndrome generator.
`default_nettype none

module sindrome_hamming
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codeword,
  output logic [SYN_W-1:0]  sindrome
);

  for (genvar k = 0; k < SYN_W; k++) begin : g_bit
    localparam logic [CODE_W-1:0] MASK = mascara_paridade(k);
    assign sindrome[k] = ^(codeword & MASK);
  end

endmodule

`default_nettype wire

// File: rtl/corretor_hamming.sv
// Two-stage Hamming(15,11) single-error corrector with valid/ready flow
// control and a saturating count of corrected words.
`default_nettype none

module corretor_hamming
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  entrada,
  input  logic               entrada_valida,
  output logic               entrada_pronta,
  output logic [DATA_W-1:0]  saida_dados,
  output logic [SYN_W-1:0]   sindrome,
  output logic               corrigido,
  output logic               saida_valida,
  input  logic               saida_pronta,
  input  logic               limpa_cont,
  output logic [CNT_W-1:0]   cont_erros
);

  logic [SYN_W-1:0]  syn_in;
  logic [SYN_W-1:0]  syn1;
  logic [CODE_W-1:0] cw1;
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] cw_corr;
  logic              v1;
  logic              v2;
  logic              adv2;
  logic              in_hs;
  logic              out_hs;

  sindrome_hamming u_sindrome (
    .codeword (entrada),
    .sindrome (syn_in)
  );

  assign adv2           = !v2 || saida_pronta;
  assign entrada_pronta = !v1 || adv2;
  assign in_hs          = entrada_valida && entrada_pronta;
  assign out_hs         = v2 && saida_pronta;
  assign saida_valida   = v2;

  // A zero syndrome matches no position, so clean words pass unchanged.
  always_comb begin
    flip = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip[i] = (syn1 == SYN_W'(i + 1));
    end
  end

  assign cw_corr = cw1 ^ flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
    end else if (in_hs) begin
      v1   <= 1'b1;
      cw1  <= entrada;
      syn1 <= syn_in;
    end else if (adv2) begin
      v1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2          <= 1'b0;
      saida_dados <= '0;
      sindrome    <= '0;
      corrigido   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        saida_dados <= extrai_dados(cw_corr);
        sindrome    <= syn1;
        corrigido   <= (syn1 != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_erros <= '0;
    end else if (limpa_cont) begin
      cont_erros <= '0;
    end else if (out_hs && corrigido && (cont_erros != {CNT_W{1'b1}})) begin
      cont_erros <= cont_erros + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/corretor_hamming.md
# corretor_hamming

Pipelined Hamming(15,11) single-error corrector. It sits directly downstream of the error injector (`injetor`) and consumes its 15-bit codeword. It computes the syndrome, flips the erroneous bit, and delivers the 11 data bits with status flags through a valid/ready interface. A saturating counter accumulates how many delivered words needed correction.

## Interface
- `CNT_W`, default 16: width of the corrected-error counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `entrada` in 15: received codeword. Bit i is Hamming position i+1.
- `entrada_valida` in 1: `entrada` is valid this cycle.
- `entrada_pronta` out 1: stage 1 can accept a word this cycle.
- `saida_dados` out 11: corrected data bits.
- `sindrome` out 4: syndrome of the delivered word (0 means clean).
- `corrigido` out 1: one bit was flipped (`sindrome` ≠ 0).
- `saida_valida` out 1: output word valid.
- `saida_pronta` in 1: downstream accepts the output word.
- `limpa_cont` in 1: synchronous clear of `cont_erros`.
- `cont_erros` out CNT_W: saturating count of delivered words with `corrigido`=1.

## Operation
- **Codeword layout**
  - Parity bits sit at indices 0, 1, 3, 7 (positions 1, 2, 4, 8).
  - Data bits are, in order: `data[0]`=idx2, `data[1]`=idx4, `data[2]`=idx5, `data[3]`=idx6, `data[10:4]`=idx14..8.
- **Syndrome**
  - `s[k]` = XOR of all `entrada[i]` where bit k of (i+1) is 1, for k = 0..3.
  - If s ≠ 0, invert codeword bit s−1; all values 1..15 are legal.
  - Only single errors are corrected. Double errors miscorrect silently; there is no detection.
- **Stage 1**
  - On an input handshake (`entrada_valida` && `entrada_pronta`), register the codeword and its syndrome, and set `v1`.
- **Stage 2**
  - When it advances, register the corrected, extracted data, `sindrome`, and `corrigido`, and set `v2`.
  - `v2` drives `saida_valida`.
- **Flow control**
  - `adv2` = !`v2` || `saida_pronta`.
  - `adv1` = `adv2`.
  - `entrada_pronta` = !`v1` || `adv2`; this is combinational.
  - `v1` clears when stage 1 advances with no new input. `v2` clears on an output handshake when stage 1 is empty.
- **Counter**
  - On an output handshake with `corrigido`=1, `cont_erros` increments.
  - It holds at all-ones (2^CNT_W−1).
  - `limpa_cont` overrides a simultaneous increment; the result is 0.
- **Reset**
  - All registers clear: `v1`=`v2`=0, `saida_dados`=0, `sindrome`=0, `corrigido`=0, `cont_erros`=0.
  - `entrada_pronta` reads 1 while empty, but nothing is captured while `rst_n`=0.
  - Reset mid-operation discards in-flight words. Counts from discarded words are not added.

## Timing
- **Latency:** a word accepted at edge k has `saida_valida`=1 after edge k+1 when `saida_pronta` stays 1.
- **Throughput:** one word per cycle with no bubbles when `saida_pronta`=1.
- **Backpressure:**
  - With `saida_pronta`=0, `v2`=1 and `v1`=1, `entrada_pronta`=0.
  - Outputs hold stable, and `saida_valida` never drops without a handshake.
  - Two words are buffered at most.
- **Pass-through:** simultaneous input and output handshakes in one cycle pass data through without loss or duplication.
- **Counter timing:** `cont_erros` updates on the edge that completes the output handshake.

## Structure
- **`hamming_pkg` contents:**
  - `CODE_W`=15, `DATA_W`=11, `SYN_W`=4.
  - The parity index constants.
  - The data-index map as a constant array.
  - The function `extrai_dados(codeword)` returning 11 bits.
- **`sindrome_hamming` sub-module:**
  - Combinational, 15-bit input, 4-bit syndrome output.
  - Instantiated once in stage 1; reused by the encoder testbench as a checker.

## Test plan
- **Clean codewords:** 15'h0000, 15'h7FFF, 15'h0007 (data 11'h001) with `saida_pronta`=1.
  - Data 11'h000, 11'h7FF, 11'h001; `sindrome`=0; `corrigido`=0.
  - Output one cycle after acceptance; `cont_erros`=0.
- **Single errors:**
  - 15'h7FDF (idx5 flipped) → data 11'h7FF, `sindrome`=6, `corrigido`=1.
  - 15'h4000 → data 11'h000, `sindrome`=15.
  - `cont_erros`=2 afterwards.
- **Every error position:** feed 15'h7FFF through `injetor` with n=0..14.
  - Every output is data 11'h7FF with `sindrome`=n+1.
  - Streamed back-to-back, one result per cycle.
- **Backpressure:** stream 4 words with `saida_pronta` held 0 for 5 cycles.
  - `entrada_pronta` falls after 2 words are accepted.
  - On release the 4 words emerge in order; none are lost or duplicated.
- **Counter saturation and clear:** `CNT_W`=2, feed 5 erroneous words.
  - `cont_erros` saturates at 3.
  - `limpa_cont` asserted on the same edge as a corrected handshake gives 0.
- **Reset mid-stream:** `rst_n` low for 1 cycle with 2 words in flight.
  - `saida_valida`=0 and `cont_erros`=0 immediately.
  - A new word after release is corrected normally.
